// File: rtl/pid_pwm_out.sv
// rtl/pid_pwm_out.sv - PID output to PWM converter with clamping, slew limit and period-aligned duty updates
module pid_pwm_out #(
    parameter int INPUT_WIDTH = 32,
    parameter int PWM_WIDTH   = 8,
    parameter int IN_SHIFT    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic signed [INPUT_WIDTH-1:0] sig_in,
    input  logic                          valid,
    input  logic        [PWM_WIDTH-1:0]   slew_max,
    output logic                          trig_out,
    output logic                          pwm,
    output logic        [PWM_WIDTH-1:0]   duty,
    output logic                          sat_hi,
    output logic                          sat_lo
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

    state_t                         r_state;
    state_t                         w_state_next;
    logic   [PWM_WIDTH-1:0]         r_cnt;
    logic   [PWM_WIDTH-1:0]         r_pending;
    logic   [PWM_WIDTH-1:0]         r_duty;
    logic                           r_pwm;
    logic                           r_trig;
    logic                           r_sat_hi;
    logic                           r_sat_lo;

    logic signed [INPUT_WIDTH-1:0]  w_shifted;
    logic                           w_neg;
    logic                           w_over;
    logic   [PWM_WIDTH-1:0]         w_target;
    logic                           w_up;
    logic   [PWM_WIDTH-1:0]         w_diff;
    logic   [PWM_WIDTH-1:0]         w_step;
    logic   [PWM_WIDTH-1:0]         w_pending_next;
    logic                           w_run_next;
    logic                           w_load_duty;

    // Clamp the scaled PID value into the unsigned duty range.
    assign w_shifted = sig_in >>> IN_SHIFT;
    assign w_neg     = w_shifted[INPUT_WIDTH-1];
    assign w_over    = !w_neg && (|w_shifted[INPUT_WIDTH-2:PWM_WIDTH]);
    assign w_target  = w_neg ? '0 : (w_over ? CNT_MAX : w_shifted[PWM_WIDTH-1:0]);

    // Step never exceeds the distance to target, so pending cannot wrap.
    assign w_up           = w_target > r_pending;
    assign w_diff         = w_up ? (w_target - r_pending) : (r_pending - w_target);
    assign w_step         = ((slew_max == '0) || (w_diff < slew_max)) ? w_diff : slew_max;
    assign w_pending_next = w_up ? (r_pending + w_step) : (r_pending - w_step);

    always_comb begin
        w_state_next = r_state;
        w_run_next   = 1'b0;
        w_load_duty  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_RUN;
                    w_load_duty  = 1'b1;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_run_next  = 1'b1;
                    w_load_duty = (r_cnt == CNT_MAX);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_pending <= '0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
            r_trig    <= 1'b0;
            r_sat_hi  <= 1'b0;
            r_sat_lo  <= 1'b0;
        end else begin
            r_cnt  <= w_run_next ? (r_cnt + 1'b1) : '0;
            r_pwm  <= w_run_next && (r_cnt < r_duty);
            r_trig <= w_run_next && (r_cnt == '0);
            // Uses pending before any same-cycle valid, so a new sample waits a full period.
            if (w_load_duty) begin
                r_duty <= r_pending;
            end
            if (valid) begin
                r_pending <= w_pending_next;
                r_sat_hi  <= w_over;
                r_sat_lo  <= w_neg;
            end
        end
    end

    assign trig_out = r_trig;
    assign pwm      = r_pwm;
    assign duty     = r_duty;
    assign sat_hi   = r_sat_hi;
    assign sat_lo   = r_sat_lo;

endmodule

// File: tb/tb_pid_pwm_out.sv
// tb/tb_pid_pwm_out.sv - self-checking bench for pid_pwm_out
module tb_pid_pwm_out;
    localparam int IW = 32;
    localparam int PW = 8;
    localparam int SH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic signed [IW-1:0] sig_in;
    logic                 valid;
    logic        [PW-1:0] slew_max;
    logic                 trig_out;
    logic                 pwm;
    logic        [PW-1:0] duty;
    logic                 sat_hi;
    logic                 sat_lo;

    pid_pwm_out #(.INPUT_WIDTH(IW), .PWM_WIDTH(PW), .IN_SHIFT(SH)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sig_in   (sig_in),
        .valid    (valid),
        .slew_max (slew_max),
        .trig_out (trig_out),
        .pwm      (pwm),
        .duty     (duty),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sig;
        int slew;
        int exp_duty;
        bit exp_hi;
        bit exp_lo;
    } vec_t;

    typedef struct {
        int duty;
        bit hi;
        bit lo;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int s, input int sl, input int d, input bit h, input bit l);
        vec_t v;
        v.sig = s; v.slew = sl; v.exp_duty = d; v.exp_hi = h; v.exp_lo = l;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic pulse_valid(input int s, input int sl);
        sig_in   = s;
        slew_max = sl[PW-1:0];
        valid    = 1'b1;
        tick();
        valid    = 1'b0;
    endtask

    task automatic wait_trig(input string tag);
        int n = 0;
        while (trig_out !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_trig_seen"}, trig_out, 1);
    endtask

    task automatic measure(input int exp_duty, input string tag);
        int waited = 0;
        int hi = 0;
        int tr = 0;
        while (duty != exp_duty[PW-1:0] && waited < 600) begin
            tick();
            waited++;
        end
        check({tag, "_settle"}, duty, exp_duty);
        for (int k = 0; k < 256; k++) begin
            tick();
            hi += int'(pwm);
            tr += int'(trig_out);
        end
        check({tag, "_pwm_high"}, hi, exp_duty);
        check({tag, "_trig_cnt"}, tr, 1);
    endtask

    initial begin
        exp_t e;
        int   changes;
        int   cnt;

        vecs[0]  = mk(16384,   0,   64, 0, 0);
        vecs[1]  = mk(-5000,   0,    0, 0, 1);
        vecs[2]  = mk(200000,  0,  255, 1, 0);
        vecs[3]  = mk(65280,   0,  255, 0, 0);
        vecs[4]  = mk(65536,   0,  255, 1, 0);
        vecs[5]  = mk(255,     0,    0, 0, 0);
        vecs[6]  = mk(-1,      0,    0, 0, 1);
        vecs[7]  = mk(32768,   0,  128, 0, 0);
        vecs[8]  = mk(25600,  10,  118, 0, 0);
        vecs[9]  = mk(65280, 200,  255, 0, 0);
        vecs[10] = mk(0,     100,  155, 0, 0);
        vecs[11] = mk(-300000, 250,  0, 0, 1);
        vecs[12] = mk(65280,   3,    3, 0, 0);
        vecs[13] = mk(256,     3,    1, 0, 0);

        reset = 1'b0; enable = 1'b0; valid = 1'b0; sig_in = '0; slew_max = '0;
        @(negedge clk);
        tick();
        check("rst_duty", duty, 0);
        check("rst_pwm", pwm, 0);
        check("rst_trig", trig_out, 0);
        check("rst_sat_hi", sat_hi, 0);
        check("rst_sat_lo", sat_lo, 0);
        reset = 1'b1;
        tick();

        // Table: sample accepted in IDLE, then a one-clock enable loads duty.
        for (int i = 0; i < 14; i++) begin
            sig_in   = vecs[i].sig;
            slew_max = vecs[i].slew[PW-1:0];
            valid    = 1'b1;
            sb.push_back('{vecs[i].exp_duty, vecs[i].exp_hi, vecs[i].exp_lo});
            tick();
            valid  = 1'b0;
            enable = 1'b1;
            e = sb[0];
            check($sformatf("vec%0d_sat_hi", i), sat_hi, e.hi);
            check($sformatf("vec%0d_sat_lo", i), sat_lo, e.lo);
            tick();
            enable = 1'b0;
            tick();
            e = sb.pop_front();
            check($sformatf("vec%0d_duty", i), duty, e.duty);
            check($sformatf("vec%0d_pwm_off", i), pwm, 0);
            check($sformatf("vec%0d_trig_off", i), trig_out, 0);
        end

        // Consecutive valids, each slew-limited from the previous pending.
        for (int k = 1; k <= 5; k++) begin
            pulse_valid(0, 0);
            sig_in = 25600; slew_max = 8'd10; valid = 1'b1;
            sb.push_back('{10 * k, 1'b0, 1'b0});
            repeat (k) tick();
            valid = 1'b0;
            enable = 1'b1;
            tick();
            enable = 1'b0;
            tick();
            e = sb.pop_front();
            check($sformatf("slew_k%0d_duty", k), duty, e.duty);
        end

        // Running: basic duty, clamping extremes.
        do_reset();
        enable = 1'b1;
        pulse_valid(16384, 0);
        measure(64, "run64");
        pulse_valid(-5000, 0);
        check("run_neg_sat_lo", sat_lo, 1);
        measure(0, "run0");
        pulse_valid(200000, 0);
        check("run_big_sat_hi", sat_hi, 1);
        measure(255, "run255");

        // Valid on the boundary clock: old pending applies this period.
        pulse_valid(16384, 0);
        measure(64, "pre_bnd");
        wait_trig("bnd");
        repeat (254) tick();
        pulse_valid(32768, 0);
        check("bnd_duty_now", duty, 64);
        changes = 0;
        for (int k = 0; k < 255; k++) begin
            tick();
            if (duty != 8'd64) changes++;
        end
        check("bnd_mid_changes", changes, 0);
        tick();
        check("bnd_duty_next", duty, 128);

        // Enable dropped mid-period, then restart.
        pulse_valid(51200, 0);
        measure(200, "run200");
        wait_trig("abort");
        repeat (99) tick();
        check("abort_pwm_before", pwm, 1);
        enable = 1'b0;
        tick();
        check("abort_pwm_after", pwm, 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            cnt += int'(trig_out) + int'(pwm);
        end
        check("abort_idle_quiet", cnt, 0);
        check("abort_duty_kept", duty, 200);
        enable = 1'b1;
        tick();
        check("restart_trig_e0", trig_out, 0);
        tick();
        check("restart_trig_e1", trig_out, 1);
        check("restart_pwm", pwm, 1);

        // Asynchronous reset mid-period.
        wait_trig("areset");
        repeat (48) tick();
        pulse_valid(200000, 0);
        check("areset_sat_before", sat_hi, 1);
        check("areset_pwm_before", pwm, 1);
        #2 reset = 1'b0;
        #1;
        check("areset_pwm", pwm, 0);
        check("areset_trig", trig_out, 0);
        check("areset_duty", duty, 0);
        check("areset_sat_hi", sat_hi, 0);
        check("areset_sat_lo", sat_lo, 0);
        @(negedge clk);
        tick();
        reset = 1'b1;
        pulse_valid(16384, 0);
        measure(64, "resume");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pid_pwm_out.md
PID_PWM_OUT -- requirements
Module: pid_pwm_out

Interface
REQ-001 Parameter INPUT_WIDTH, default 32, SHALL set the width of the signed PID output accepted on sig_in.
REQ-002 Parameter PWM_WIDTH, default 8, SHALL set the PWM counter and duty width; period = 2^PWM_WIDTH clocks.
REQ-003 Parameter IN_SHIFT, default 8, SHALL set the arithmetic right shift applied to sig_in before clamping.
REQ-004 The ports SHALL be exactly as follows:
  clk  input  1  single system clock, all logic on rising edge.
  reset  input  1  asynchronous, active-low reset (0 = reset asserted).
  enable  input  1  1 = run PWM, 0 = idle.
  sig_in  input  INPUT_WIDTH  signed PID output (connects to PID sig_out).
  valid  input  1  one-clock strobe qualifying sig_in (connects to PID done).
  slew_max  input  PWM_WIDTH  unsigned maximum duty change per accepted sample; 0 = unlimited.
  trig_out  output  1  one-clock request for a new PID calculation (connects to PID trig).
  pwm  output  1  PWM waveform.
  duty  output  PWM_WIDTH  duty currently applied to pwm.
  sat_hi  output  1  last accepted sample clamped high.
  sat_lo  output  1  last accepted sample clamped low.

Function
REQ-005 The block SHALL have two states, IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0, evaluated every clock.
REQ-006 In IDLE: counter held at 0, pwm=0, trig_out=0; duty and pending duty retain their values.
REQ-007 In RUN: counter SHALL increment by 1 each clock, wrapping from 2^PWM_WIDTH-1 to 0.
REQ-008 pwm SHALL be registered, 1 when RUN and counter < duty, else 0; duty=0 gives constant 0, duty=2^PWM_WIDTH-1 gives high for all but one clock per period.
REQ-009 trig_out SHALL pulse high for exactly one clock on the cycle after the counter equals 0 in RUN, i.e. once per period; first pulse one clock after entering RUN.
REQ-010 On valid=1: s = sig_in >>> IN_SHIFT (sign-preserving); target = 0 if s<0 (sat_lo=1, sat_hi=0), 2^PWM_WIDTH-1 if s>2^PWM_WIDTH-1 (sat_hi=1, sat_lo=0), else s (both flags 0).
REQ-011 Slew: if slew_max=0 pending=target; else pending SHALL move toward target by min(|target-pending|, slew_max); no overflow/underflow past 0 or 2^PWM_WIDTH-1.
REQ-012 Pending, sat_hi, sat_lo SHALL update the clock after valid; valid is accepted in both IDLE and RUN.
REQ-013 duty SHALL load from pending only on the clock where counter wraps to 0 (period boundary) or on IDLE->RUN transition, so duty never changes mid-period.
REQ-014 valid coincident with the boundary load: duty SHALL take the pending value from before that valid; the new value applies from the next boundary.
REQ-015 valid asserted on consecutive clocks SHALL be processed every clock, each step slew-limited from the previous pending.
REQ-016 enable deasserted mid-period SHALL force pwm=0 on the next clock and abort the period; re-enable SHALL restart at counter 0.

Reset
REQ-017 While reset=0, asynchronously: state=IDLE, counter=0, pending=0, duty=0, pwm=0, trig_out=0, sat_hi=0, sat_lo=0.
REQ-018 Reset asserted mid-period SHALL force all outputs to REQ-017 values immediately; after release, operation resumes from IDLE per enable.

Verification (defaults INPUT_WIDTH=32, PWM_WIDTH=8, IN_SHIFT=8)
REQ-019 Reset, enable=1, slew_max=0, valid with sig_in=16384 -> pending=64; at next boundary duty=64; pwm high 64 of every 256 clocks; trig_out one pulse per 256 clocks.
REQ-020 sig_in=-5000 -> duty 0, sat_lo=1, pwm constantly 0; sig_in=200000 -> duty 255, sat_hi=1, pwm low 1 clock per period.
REQ-021 slew_max=10, pending=0, five valids with sig_in=25600 -> pending 10,20,30,40,50 one clock after each valid.
REQ-022 valid with sig_in=32768 on the boundary clock while pending=64 -> duty=64 this period, 128 from the next boundary; no mid-period duty change.
REQ-023 enable dropped at counter=100 with duty=200 -> pwm=0 next clock, no trig_out; enable re-raised -> counter restarts at 0, trig_out pulse one clock later.
REQ-024 reset pulled low at counter=50 -> pwm, trig_out, duty, flags 0 without waiting for clk; after release, behaviour matches REQ-019.
